// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 SPI transmit path.
// FSM state encoding and FIFO entry width ({dc, data[7:0]}).
package oled_pkg;

    localparam int OLED_ENTRY_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH
    } oled_state_e;

endpackage

// File: rtl/oled_tx_fifo.sv
// Small synchronous FIFO for {dc, data} entries feeding the SPI shifter.
// The head entry is read straight from the array so the shifter can pop
// and use it in the same LOAD cycle; a push into an empty FIFO is only
// visible from the following cycle (no bypass).
module oled_tx_fifo
    import oled_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OLED_ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // Pointer and occupancy next-state; simultaneous push and pop keep the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointer/level registers; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-level SPI (mode 0, MSB first) transmitter for the SSD1306 OLED.
// Bytes tagged with D/C are buffered in oled_tx_fifo and shifted out on
// oled_sclk/oled_sdin; done pulses once per byte at its last SCLK fall.
// Optional chip-select output: define OLED_SPI_TX_CS_EN.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    input  logic                          in_dc,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          oled_sclk,
    output logic                          oled_sdin,
    output logic                          oled_dc
`ifdef OLED_SPI_TX_CS_EN
    ,
    output logic                          oled_cs_n
`endif
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    oled_state_e            state_q, state_d;
    logic [7:0]             div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic [6:0]             shift_q, shift_d;
    logic                   sclk_q, sclk_d;
    logic                   sdin_q, sdin_d;
    logic                   dc_q, dc_d;
    logic                   done_q, done_d;
`ifdef OLED_SPI_TX_CS_EN
    logic                   cs_n_q, cs_n_d;
`endif

    logic                   pop;
    logic [OLED_ENTRY_W-1:0] head;
    logic                   fifo_full, fifo_empty;
    logic                   div_last;

    oled_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OLED_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid),
        .push_data_i ({in_dc, in_data}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign done      = done_q;
    assign oled_sclk = sclk_q;
    assign oled_sdin = sdin_q;
    assign oled_dc   = dc_q;
    assign div_last  = (div_q == DIV_LAST);
`ifdef OLED_SPI_TX_CS_EN
    assign oled_cs_n = cs_n_q;
`endif

    // Next-state: divider paces each SCLK half period, data moves only on falls.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        sdin_d  = sdin_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef OLED_SPI_TX_CS_EN
        cs_n_d  = cs_n_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef OLED_SPI_TX_CS_EN
                // Release CS one cycle after the final byte completes.
                if (done_q) begin
                    cs_n_d = 1'b1;
                end
`endif
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                dc_d    = head[8];
                sdin_d  = head[7];
                shift_d = head[6:0];
                bit_d   = 3'd7;
                div_d   = '0;
                state_d = LOW;
`ifdef OLED_SPI_TX_CS_EN
                cs_n_d  = 1'b0;
`endif
            end
            LOW: begin
                if (div_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != 3'd0) begin
                        sdin_d  = shift_q[6];
                        shift_d = {shift_q[5:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                        state_d = LOW;
                    end else begin
                        // Last bit: sdin keeps data[0] while idle.
                        done_d  = 1'b1;
                        state_d = fifo_empty ? IDLE : LOAD;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops the partial byte and forces idle outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef OLED_SPI_TX_CS_EN
            cs_n_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
`ifdef OLED_SPI_TX_CS_EN
            cs_n_q  <= cs_n_d;
`endif
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: main instance at CLK_DIV=4, a second
// instance at CLK_DIV=1 for the fastest-divider case.
module tb_oled_spi_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Main instance (CLK_DIV = 4)
    logic       v = 1'b0, dcv = 1'b0;
    logic [7:0] d = 8'h00;
    logic       in_ready, busy, done, sclk, sdin, dc;
    logic [2:0] level;
`ifdef OLED_SPI_TX_CS_EN
    logic       cs_n;
`endif

    // Fast instance (CLK_DIV = 1)
    logic       v1 = 1'b0, dc1v = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       in_ready1, busy1, done1, sclk1, sdin1, dc1;
    logic [2:0] level1;
`ifdef OLED_SPI_TX_CS_EN
    logic       cs_n1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oled_spi_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(v), .in_ready(in_ready),
        .in_data(d), .in_dc(dcv), .busy(busy), .done(done),
        .fifo_level(level), .oled_sclk(sclk), .oled_sdin(sdin), .oled_dc(dc)
`ifdef OLED_SPI_TX_CS_EN
        , .oled_cs_n(cs_n)
`endif
    );

    oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1),
        .in_data(d1), .in_dc(dc1v), .busy(busy1), .done(done1),
        .fifo_level(level1), .oled_sclk(sclk1), .oled_sdin(sdin1), .oled_dc(dc1)
`ifdef OLED_SPI_TX_CS_EN
        , .oled_cs_n(cs_n1)
`endif
    );

    // Monitor of the main instance, sampled 1 time unit after each edge.
    logic rise_bits[$];
    int   rise_cyc[$];
    int   done_cyc[$];
    logic done_dc[$];
    int   dc_chg[$];
    logic prev_sclk = 1'b0, prev_dc = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_bits.push_back(sdin);
            rise_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_dc.push_back(dc);
        end
        if (dc !== prev_dc) dc_chg.push_back(cyc);
        prev_sclk = sclk;
        prev_dc   = dc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_mon;
        rise_bits.delete();
        rise_cyc.delete();
        done_cyc.delete();
        done_dc.delete();
        dc_chg.delete();
    endtask

    // Push one byte into the main instance; returns the accept edge index.
    task automatic push(input logic [7:0] data, input logic dcin, output int acc);
        logic r;
        acc = -1;
        v = 1'b1; d = data; dcv = dcin;
        for (int i = 0; i < 400; i++) begin
            r = in_ready;
            tick();
            if (r) begin
                acc = cyc;
                break;
            end
        end
        v = 1'b0;
        chk("push_accepted", (acc >= 0), 1'b1);
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() >= n) break;
            tick();
        end
        chk("done_count", done_cyc.size(), n);
    endtask

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], (base + i < rise_bits.size()) ? rise_bits[base + i] : 1'bx};
        end
        return r;
    endfunction

    initial begin : stim
        int n, n2, idx, maxlvl, last_rise;
        logic saw_full, ready_at_full, r, pre, b;
        logic [7:0] t3 [6];
        logic [7:0] fb;
        int d1c, rises1;

        // ---------------- Reset state ----------------
        repeat (3) tick();
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_sdin", sdin, 1'b0);
        chk("rst_dc", dc, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 3'd0);
`ifdef OLED_SPI_TX_CS_EN
        chk("rst_cs_n", cs_n, 1'b1);
`endif
        rst = 1'b0;
        tick();
        chk("ready_after_rst", in_ready, 1'b1);

        // ---------------- T1: single byte 0xA5, dc=0 ----------------
        clear_mon();
        push(8'hA5, 1'b0, n);
        wait_dones(1, 200);
        chk("t1_done_latency", qi(done_cyc, 0) - n, 66);
        chk("t1_first_rise", qi(rise_cyc, 0) - n, 6);
        chk("t1_rises", rise_bits.size(), 8);
        chk("t1_byte", byte_at(0), 8'hA5);
        chk("t1_dc", (done_dc.size() > 0) ? done_dc[0] : 1'bx, 1'b0);
        repeat (3) tick();
        chk("t1_sdin_hold", sdin, 1'b1);
        chk("t1_idle_busy", busy, 1'b0);
        $display("T1 byte=%02h done_latency=%0d", byte_at(0), qi(done_cyc, 0) - n);

        // ---------------- T2: three back-to-back bytes ----------------
        clear_mon();
        push(8'hAE, 1'b0, n);
        push(8'hFF, 1'b1, n2);
        push(8'h00, 1'b1, n2);
        wait_dones(3, 400);
        chk("t2_gap1", qi(done_cyc, 1) - qi(done_cyc, 0), 65);
        chk("t2_gap2", qi(done_cyc, 2) - qi(done_cyc, 1), 65);
        chk("t2_byte0", byte_at(0), 8'hAE);
        chk("t2_byte1", byte_at(8), 8'hFF);
        chk("t2_byte2", byte_at(16), 8'h00);
        chk("t2_dc1", (done_dc.size() > 1) ? done_dc[1] : 1'bx, 1'b1);
        chk("t2_dc_changes", dc_chg.size(), 1);
        chk("t2_dc_switch", qi(dc_chg, 0), qi(done_cyc, 0) + 1);
        $display("T2 bytes=%02h %02h %02h gaps=%0d %0d", byte_at(0), byte_at(8), byte_at(16),
                 qi(done_cyc, 1) - qi(done_cyc, 0), qi(done_cyc, 2) - qi(done_cyc, 1));

        // ---------------- T3: overfill the FIFO ----------------
        clear_mon();
        t3[0] = 8'h11; t3[1] = 8'h22; t3[2] = 8'h33;
        t3[3] = 8'h44; t3[4] = 8'h55; t3[5] = 8'h66;
        idx = 0; maxlvl = 0; saw_full = 1'b0; ready_at_full = 1'b1;
        v = 1'b1; dcv = 1'b0;
        for (int i = 0; i < 600 && idx < 6; i++) begin
            d = t3[idx];
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (level == 3'd4 && !saw_full) begin
                saw_full = 1'b1;
                ready_at_full = in_ready;
            end
            r = in_ready;
            tick();
            if (r) idx++;
        end
        v = 1'b0;
        chk("t3_all_accepted", idx, 6);
        chk("t3_saw_full", saw_full, 1'b1);
        chk("t3_ready_at_full", ready_at_full, 1'b0);
        chk("t3_max_level", maxlvl, 4);
        wait_dones(6, 600);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_byte%0d", k), byte_at(8 * k), t3[k]);
        end
        chk("t3_rises", rise_bits.size(), 48);
        $display("T3 out=%02h %02h %02h %02h %02h %02h", byte_at(0), byte_at(8), byte_at(16),
                 byte_at(24), byte_at(32), byte_at(40));

        // ---------------- T4: reset during bit 3 of 0x3C ----------------
        clear_mon();
        push(8'h3C, 1'b0, n);
        push(8'h11, 1'b1, n2);
        push(8'h22, 1'b1, n2);
        for (int i = 0; i < 200; i++) begin
            if (rise_bits.size() >= 5) break;
            tick();
        end
        pre = sclk;
        chk("t4_sclk_high_before", pre, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t4_sclk", sclk, 1'b0);
        chk("t4_done", done, 1'b0);
        chk("t4_level", level, 3'd0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_dc", dc, 1'b0);
        tick(); tick();
        rst = 1'b0;
        clear_mon();
        repeat (150) tick();
        chk("t4_no_done", done_cyc.size(), 0);
        chk("t4_no_sclk", rise_bits.size(), 0);
        push(8'h81, 1'b1, n);
        wait_dones(1, 200);
        chk("t4_new_byte", byte_at(0), 8'h81);
        chk("t4_new_rises", rise_bits.size(), 8);
        chk("t4_new_latency", qi(done_cyc, 0) - n, 66);
        $display("T4 after reset byte=%02h", byte_at(0));

        // ---------------- T5: CLK_DIV=1, byte 0x01 ----------------
        v1 = 1'b1; d1 = 8'h01; dc1v = 1'b0;
        r = in_ready1;
        tick();
        n = cyc;
        v1 = 1'b0;
        chk("t5_ready", r, 1'b1);
        d1c = -1000; rises1 = 0; fb = 8'h00; last_rise = -1000; pre = sclk1;
        for (int i = 0; i < 40; i++) begin
            tick();
            b = sclk1;
            if (b === 1'b1 && pre === 1'b0) begin
                rises1++;
                fb = {fb[6:0], sdin1};
                last_rise = cyc;
            end
            pre = b;
            if (done1 === 1'b1 && d1c < 0) d1c = cyc;
        end
        chk("t5_done_latency", d1c - n, 18);
        chk("t5_rises", rises1, 8);
        chk("t5_byte", fb, 8'h01);
        chk("t5_last_rise", last_rise - n, 17);
        chk("t5_sdin_hold", sdin1, 1'b1);
        $display("T5 div1 byte=%02h done_latency=%0d", fb, d1c - n);

`ifdef OLED_SPI_TX_CS_EN
        // ---------------- T6: chip select across back-to-back bytes ----------------
        begin
            int fall_c, rise_c, trans;
            logic pc;
            clear_mon();
            fall_c = -1000; rise_c = -1000; trans = 0;
            pc = cs_n;
            push(8'h12, 1'b0, n);
            if (cs_n !== pc) begin trans++; fall_c = cyc; end
            pc = cs_n;
            push(8'h34, 1'b1, n2);
            if (cs_n !== pc) begin trans++; fall_c = cyc; end
            pc = cs_n;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (cs_n !== pc) begin
                    trans++;
                    if (cs_n === 1'b0) fall_c = cyc; else rise_c = cyc;
                end
                pc = cs_n;
            end
            chk("t6_dones", done_cyc.size(), 2);
            chk("t6_cs_fall", fall_c - n, 2);
            chk("t6_cs_rise", rise_c, qi(done_cyc, 1) + 1);
            chk("t6_cs_transitions", trans, 2);
            $display("T6 cs fall=%0d rise=%0d", fall_c - n, rise_c - qi(done_cyc, 1));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
